// File: rtl/l2sw_arb_pkg.sv
// Shared definitions for the L2 switch ingress arbiter.
//   arb_state_t       : arbiter FSM encoding (S_IDLE / S_GRANT / S_RELEASE)
//   HEADER_DWIDTH_DEF : default header FIFO word width
//   CTRL_FLAG_BIT     : header bit marking a control frame
//   FCS_OK_BIT        : header bit carrying the FCS-good status
//   GRANT_IW          : width of the granted-port index
package l2sw_arb_pkg;

  localparam int HEADER_DWIDTH_DEF = 128;
  localparam int CTRL_FLAG_BIT     = 114;
  localparam int FCS_OK_BIT        = 115;
  localparam int GRANT_IW          = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rx_port_arbiter_if.sv
// Bus bundle between the per-port ingress FIFOs, the arbiter and the shared
// consumer.
//   in_h_dout/in_h_empty/in_h_rden          : per-port header FIFO read side
//   in_b_dout/in_b_empty/in_b_del/in_b_rden : per-port body FIFO read side
//   out_h_*/out_b_*                         : muxed view seen by the consumer
// Modports: master = arbiter, slave = FIFOs plus consumer (environment).
interface rx_port_arbiter_if
  import l2sw_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int HEADER_DWIDTH = HEADER_DWIDTH_DEF
);

  logic [NUM_PORTS-1:0][HEADER_DWIDTH-1:0] in_h_dout;
  logic [NUM_PORTS-1:0]                    in_h_empty;
  logic [NUM_PORTS-1:0]                    in_h_rden;
  logic [NUM_PORTS-1:0][7:0]               in_b_dout;
  logic [NUM_PORTS-1:0]                    in_b_empty;
  logic [NUM_PORTS-1:0]                    in_b_del;
  logic [NUM_PORTS-1:0]                    in_b_rden;

  logic [HEADER_DWIDTH-1:0]                out_h_dout;
  logic                                    out_h_empty;
  logic                                    out_h_rden;
  logic [7:0]                              out_b_dout;
  logic                                    out_b_empty;
  logic                                    out_b_del;
  logic                                    out_b_rden;

  modport master (
    input  in_h_dout, in_h_empty, in_b_dout, in_b_empty, in_b_del,
    output in_h_rden, in_b_rden,
    output out_h_dout, out_h_empty, out_b_dout, out_b_empty, out_b_del,
    input  out_h_rden, out_b_rden
  );

  modport slave (
    output in_h_dout, in_h_empty, in_b_dout, in_b_empty, in_b_del,
    input  in_h_rden, in_b_rden,
    input  out_h_dout, out_h_empty, out_b_dout, out_b_empty, out_b_del,
    output out_h_rden, out_b_rden
  );

endinterface

// File: rtl/rx_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector, one bit per port
//   last  : index of the most recently served port
//   found : at least one request is set
//   idx   : first requesting port searching from last+1 (mod N), wrapping
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  // k runs 1..N so the port just served is considered last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rx_port_arbiter.sv
// rx_port_arbiter: frame-granular round-robin arbiter that steers NUM_PORTS
// ingress header/body FIFO pairs onto one shared consumer.
//   clk, arst_n    : clock (rising edge), asynchronous active-low reset
//   bus (master)   : per-port FIFO read side and muxed consumer view
//   grant_valid    : a port is currently locked to the consumer
//   grant_id       : index of the granted port
//   frames_served  : wrapping count of header pops (completed frames)
// Optional feature: define RX_ARB_CTRL_PRIORITY_EN to favour ports whose
// head-of-queue header has the control-frame flag set.
module rx_port_arbiter
  import l2sw_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int HEADER_DWIDTH = HEADER_DWIDTH_DEF
) (
  input  logic                clk,
  input  logic                arst_n,
  rx_port_arbiter_if.master   bus,
  output logic                grant_valid,
  output logic [GRANT_IW-1:0] grant_id,
  output logic [15:0]         frames_served
);

  arb_state_t           state, state_nxt;
  logic [GRANT_IW-1:0]  last_grant;
  logic [NUM_PORTS-1:0] req;
  logic                 pick_found;
  logic [GRANT_IW-1:0]  pick_idx;
  logic                 granted;

  assign req     = ~bus.in_h_empty;
  assign granted = (state == S_GRANT);

`ifdef RX_ARB_CTRL_PRIORITY_EN
  logic [NUM_PORTS-1:0] ctrl_req;
  logic                 ctrl_found, any_found;
  logic [GRANT_IW-1:0]  ctrl_idx, any_idx;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ctrl
    assign ctrl_req[i] = req[i] & bus.in_h_dout[i][CTRL_FLAG_BIT];
  end

  rr_pick #(.N(NUM_PORTS), .IW(GRANT_IW)) u_pick_ctrl (
    .req(ctrl_req), .last(last_grant), .found(ctrl_found), .idx(ctrl_idx)
  );
  rr_pick #(.N(NUM_PORTS), .IW(GRANT_IW)) u_pick_any (
    .req(req), .last(last_grant), .found(any_found), .idx(any_idx)
  );

  // Control frames win; plain round-robin only when none is waiting.
  assign pick_found = ctrl_found | any_found;
  assign pick_idx   = ctrl_found ? ctrl_idx : any_idx;
`else
  rr_pick #(.N(NUM_PORTS), .IW(GRANT_IW)) u_pick_any (
    .req(req), .last(last_grant), .found(pick_found), .idx(pick_idx)
  );
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // The grant ends only on a header pop; body pops never release it.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pick_found) state_nxt = S_GRANT;
      S_GRANT:   if (bus.out_h_rden) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // last_grant resets to the top port so port 0 wins the first arbitration.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      grant_id      <= '0;
      last_grant    <= GRANT_IW'(NUM_PORTS - 1);
      frames_served <= '0;
    end else begin
      if (state == S_IDLE && pick_found)
        grant_id <= pick_idx;
      if (granted && bus.out_h_rden) begin
        last_grant    <= grant_id;
        frames_served <= frames_served + 16'd1;
      end
    end
  end

  assign grant_valid = granted;

  // Outside S_GRANT (including illegal encodings) the consumer sees empty
  // FIFOs and its pops go nowhere.
  always_comb begin
    bus.out_h_dout  = '0;
    bus.out_h_empty = 1'b1;
    bus.out_b_dout  = '0;
    bus.out_b_empty = 1'b1;
    bus.out_b_del   = 1'b0;
    bus.in_h_rden   = '0;
    bus.in_b_rden   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (granted && grant_id == GRANT_IW'(i)) begin
        bus.out_h_dout   = bus.in_h_dout[i];
        bus.out_h_empty  = bus.in_h_empty[i];
        bus.out_b_dout   = bus.in_b_dout[i];
        bus.out_b_empty  = bus.in_b_empty[i];
        bus.out_b_del    = bus.in_b_del[i];
        bus.in_h_rden[i] = bus.out_h_rden;
        bus.in_b_rden[i] = bus.out_b_rden;
      end
    end
  end

endmodule

// File: doc/rx_port_arbiter.md
RX_PORT_ARBITER -- requirements
Module: rx_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of ingress header/body FIFO pairs (2..8).
REQ-002 SHALL have parameter HEADER_DWIDTH, default 128, header FIFO word width.
REQ-003 SHALL have port clk, in, 1, clock; all logic is on the rising edge.
REQ-004 SHALL have port arst_n, in, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports in_h_dout (in, NUM_PORTS*HEADER_DWIDTH), in_h_empty (in, NUM_PORTS) and in_h_rden (out, NUM_PORTS): per-port header FIFO data, empty flag and pop.
REQ-006 SHALL have ports in_b_dout (in, NUM_PORTS*8), in_b_empty (in, NUM_PORTS), in_b_del (in, NUM_PORTS) and in_b_rden (out, NUM_PORTS): per-port body FIFO byte, empty flag, delimiter and pop.
REQ-007 SHALL have ports out_h_dout (out, HEADER_DWIDTH), out_h_empty (out, 1) and out_h_rden (in, 1): muxed header view presented to the shared consumer, and the consumer's pop.
REQ-008 SHALL have ports out_b_dout (out, 8), out_b_empty (out, 1), out_b_del (out, 1) and out_b_rden (in, 1): muxed body view presented to the shared consumer, and the consumer's pop.
REQ-009 SHALL have ports grant_valid (out, 1), grant_id (out, 3) and frames_served (out, 16): lock status, granted port index and wrapping count of completed frames.

Function
REQ-010 SHALL implement a three-state FSM: S_IDLE, S_GRANT, S_RELEASE.
REQ-011 In S_IDLE, if any in_h_empty[i]==0, the FSM SHALL select a port round-robin, starting at last_grant+1 modulo NUM_PORTS.
REQ-012 In S_IDLE, the selected index SHALL be registered into grant_id and the FSM SHALL enter S_GRANT on the next edge (1-cycle arbitration latency).
REQ-013 In S_IDLE with all ports empty, the FSM SHALL remain in S_IDLE.
REQ-014 In S_GRANT, out_h_dout, out_h_empty, out_b_dout, out_b_empty and out_b_del SHALL combinationally reflect port grant_id.
REQ-015 In S_GRANT, in_h_rden[grant_id]=out_h_rden and in_b_rden[grant_id]=out_b_rden; all other rden bits SHALL be 0.
REQ-016 Outside S_GRANT, out_h_empty=1, out_b_empty=1, out_b_del=0 and all in_*_rden=0; consumer pops are ignored.
REQ-017 Grant SHALL be frame-granular: in S_GRANT, out_h_rden==1 forwards the pop, sets last_grant<=grant_id, increments frames_served (16-bit wrap), and enters S_RELEASE.
REQ-018 S_RELEASE SHALL last exactly one cycle and then return to S_IDLE, giving a minimum 2-cycle gap between grants so the consumer never samples a stale header.
REQ-019 Body pops without a header pop SHALL NOT end the grant, no matter how many bytes are popped.
REQ-020 grant_valid SHALL be 1 only in S_GRANT.
REQ-021 A port whose header FIFO empties while granted SHALL stay granted; out_h_empty then reflects that port's empty flag.
REQ-022 Illegal FSM encodings SHALL recover to S_IDLE with all rden=0.

Reset
REQ-023 On arst_n low, the block SHALL set: FSM=S_IDLE, grant_id=0, last_grant=NUM_PORTS-1 (port 0 wins first), frames_served=0, grant_valid=0.
REQ-024 Reset mid-grant SHALL immediately drop all rden outputs; the partially read frame is not recovered.

Configuration
REQ-025 With macro RX_ARB_CTRL_PRIORITY_EN defined, the S_IDLE selection SHALL first apply round-robin among non-empty ports whose header bit 114 (control-frame flag) is 1, and fall back to round-robin over all non-empty ports only if none has the flag set.
REQ-026 Without RX_ARB_CTRL_PRIORITY_EN, the S_IDLE selection SHALL be plain round-robin and header contents SHALL NOT affect arbitration.

Structure
REQ-027 Shared package l2sw_arb_pkg SHALL hold the FSM state encodings, HEADER_DWIDTH default, CTRL_FLAG_BIT=114 and FCS_OK_BIT=115.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module rr_pick: inputs request vector and last index; outputs found and index.
REQ-029 All other logic SHALL stay in rx_port_arbiter.

Verification
REQ-030 Scenario: after reset, ports 1 and 3 non-empty -> port 1 granted (grant_id=1), 3 cycles after the header pop port 3 granted, frames_served=2.
REQ-031 Scenario: all 4 ports continuously non-empty, 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Scenario: granted port 2, consumer pops 60 body bytes with no header pop -> grant_id stays 2 and in_b_rden active only on bit 2.
REQ-033 Scenario: consumer asserts out_h_rden in S_RELEASE/S_IDLE -> no in_h_rden bit asserted and frames_served unchanged.
REQ-034 Scenario (RX_ARB_CTRL_PRIORITY_EN): last_grant=0, port 1 data header, port 3 header bit114=1 -> port 3 granted; same stimulus without macro -> port 1 granted.
REQ-035 Scenario: arst_n pulsed while in S_GRANT -> rden=0 within the reset, grant_valid=0, first grant after release goes to port 0 if non-empty.
